idex_hazard_ctrl: RTL and testbench

- Control end of the ID/EX pipeline register in the 5-stage RV32I core.
- Produces what the register only carries: load-use stalls, mispredict flushes, EX-operand forwarding selects and the halt-drain sequence.
- Consumes ID-stage operand ids plus the ID/EX, EX/MEM and MEM/WB register outputs.
- Drives PC/IF-ID write enables and the ID/EX bubble (valid_in forced 0).
- Keeps stall/flush performance counters.

---
 rtl/idex_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_idex_hazard_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idex_hazard_ctrl.sv
// ID/EX hazard control: load-use stalls, mispredict flushes, EX operand forwarding
// selects, the halt-drain sequence, and saturating stall/flush counters.
module idex_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1_id,
    input  logic [4:0]       id_rs2_id,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_valid,
    input  logic             ex_wb_enable,
    input  logic             ex_mem_enable,
    input  logic             ex_mem_write,
    input  logic             ex_is_halted,
    input  logic [4:0]       ex_rd_id,
    input  logic [4:0]       ex_rs1_id,
    input  logic [4:0]       ex_rs2_id,
    input  logic             ex_mispredict,
    input  logic             mem_valid,
    input  logic             mem_wb_enable,
    input  logic             mem_ex_forwardable,
    input  logic [4:0]       mem_rd_id,
    input  logic             wb_valid,
    input  logic             wb_wb_enable,
    input  logic [4:0]       wb_rd_id,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_rs1_sel,
    output logic [1:0]       fwd_rs2_sel,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned REG_W   = 5;
    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
    localparam logic [REG_W-1:0]   X0         = '0;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state;
    logic [DRAIN_W-1:0] drain_cnt;

    logic load_in_ex;
    logic load_use;
    logic halt_start;
    logic mem_can_fwd;
    logic wb_can_fwd;
    logic flush_event;
    logic stall_event;

    assign load_in_ex = ex_valid & ex_mem_enable & ~ex_mem_write & ex_wb_enable
                        & (ex_rd_id != X0);
    assign load_use   = id_valid & load_in_ex
                        & ((id_uses_rs1 & (id_rs1_id == ex_rd_id))
                         | (id_uses_rs2 & (id_rs2_id == ex_rd_id)));
    assign halt_start = (state == RUN) & ex_valid & ex_is_halted;

    assign mem_can_fwd = mem_valid & mem_wb_enable & mem_ex_forwardable & (mem_rd_id != X0);
    assign wb_can_fwd  = wb_valid & wb_wb_enable & (wb_rd_id != X0);

    // EX/MEM holds the younger result, so it takes precedence over MEM/WB.
    always_comb begin
        fwd_rs1_sel = FWD_RF;
        fwd_rs2_sel = FWD_RF;
        if (mem_can_fwd && (mem_rd_id == ex_rs1_id)) begin
            fwd_rs1_sel = FWD_MEM;
        end else if (wb_can_fwd && (wb_rd_id == ex_rs1_id)) begin
            fwd_rs1_sel = FWD_WB;
        end
        if (mem_can_fwd && (mem_rd_id == ex_rs2_id)) begin
            fwd_rs2_sel = FWD_MEM;
        end else if (wb_can_fwd && (wb_rd_id == ex_rs2_id)) begin
            fwd_rs2_sel = FWD_WB;
        end
    end

    // Pipeline enables: halt/freeze over mispredict over load-use.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        flush_event = 1'b0;
        stall_event = 1'b0;
        if ((state != RUN) || halt_start) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (ex_mispredict) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_event = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_event = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            drain_cnt   <= '0;
            halted      <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_event && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (flush_event && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
            case (state)
                RUN: begin
                    if (halt_start) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// Randomized plus directed bench for idex_hazard_ctrl against a cycle-level
// reference model of the hazard rules (drain countdown, saturating counters).
module tb_idex_hazard_ctrl;

    localparam int unsigned DRAIN_CYCLES = 3;
    localparam int unsigned CNT_W        = 4;
    localparam int          CNT_MAX      = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             id_valid;
    logic [4:0]       id_rs1_id;
    logic [4:0]       id_rs2_id;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             ex_valid;
    logic             ex_wb_enable;
    logic             ex_mem_enable;
    logic             ex_mem_write;
    logic             ex_is_halted;
    logic [4:0]       ex_rd_id;
    logic [4:0]       ex_rs1_id;
    logic [4:0]       ex_rs2_id;
    logic             ex_mispredict;
    logic             mem_valid;
    logic             mem_wb_enable;
    logic             mem_ex_forwardable;
    logic [4:0]       mem_rd_id;
    logic             wb_valid;
    logic             wb_wb_enable;
    logic [4:0]       wb_rd_id;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic [1:0]       fwd_rs1_sel;
    logic [1:0]       fwd_rs2_sel;
    logic             halted;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    idex_hazard_ctrl #(
        .DRAIN_CYCLES(DRAIN_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .id_valid          (id_valid),
        .id_rs1_id         (id_rs1_id),
        .id_rs2_id         (id_rs2_id),
        .id_uses_rs1       (id_uses_rs1),
        .id_uses_rs2       (id_uses_rs2),
        .ex_valid          (ex_valid),
        .ex_wb_enable      (ex_wb_enable),
        .ex_mem_enable     (ex_mem_enable),
        .ex_mem_write      (ex_mem_write),
        .ex_is_halted      (ex_is_halted),
        .ex_rd_id          (ex_rd_id),
        .ex_rs1_id         (ex_rs1_id),
        .ex_rs2_id         (ex_rs2_id),
        .ex_mispredict     (ex_mispredict),
        .mem_valid         (mem_valid),
        .mem_wb_enable     (mem_wb_enable),
        .mem_ex_forwardable(mem_ex_forwardable),
        .mem_rd_id         (mem_rd_id),
        .wb_valid          (wb_valid),
        .wb_wb_enable      (wb_wb_enable),
        .wb_rd_id          (wb_rd_id),
        .pc_write          (pc_write),
        .ifid_write        (ifid_write),
        .ifid_flush        (ifid_flush),
        .idex_bubble       (idex_bubble),
        .fwd_rs1_sel       (fwd_rs1_sel),
        .fwd_rs2_sel       (fwd_rs2_sel),
        .halted            (halted),
        .stall_count       (stall_count),
        .flush_count       (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: cycles of drain still outstanding, halted flag, plain counters.
    int m_drain  = 0;
    bit m_halted = 1'b0;
    int m_stall  = 0;
    int m_flush  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_load_use();
        bit ex_is_load;
        ex_is_load = ex_valid && ex_mem_enable && !ex_mem_write && ex_wb_enable && ex_rd_id != 0;
        return id_valid && ex_is_load &&
               ((id_uses_rs1 && id_rs1_id == ex_rd_id) || (id_uses_rs2 && id_rs2_id == ex_rd_id));
    endfunction

    // Source code of the nearest older stage that can supply register src.
    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (src == 0) return 2'd0;
        if (mem_valid && mem_wb_enable && mem_ex_forwardable && mem_rd_id == src) return 2'd1;
        if (wb_valid && wb_wb_enable && wb_rd_id == src) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit ref_running();
        return !m_halted && m_drain == 0;
    endfunction

    // Let combinational outputs settle after new inputs, then compare everything.
    task automatic settle();
        bit halt_now;
        logic [3:0] exp_ctl;
        #1;
        halt_now = ref_running() && ex_valid && ex_is_halted;
        if (!ref_running() || halt_now) exp_ctl = 4'b0011;
        else if (ex_mispredict)         exp_ctl = 4'b1111;
        else if (ref_load_use())        exp_ctl = 4'b0001;
        else                            exp_ctl = 4'b1100;
        check("pc_write",    32'(pc_write),    32'(exp_ctl[3]));
        check("ifid_write",  32'(ifid_write),  32'(exp_ctl[2]));
        check("ifid_flush",  32'(ifid_flush),  32'(exp_ctl[1]));
        check("idex_bubble", 32'(idex_bubble), 32'(exp_ctl[0]));
        check("fwd_rs1_sel", 32'(fwd_rs1_sel), 32'(ref_fwd(ex_rs1_id)));
        check("fwd_rs2_sel", 32'(fwd_rs2_sel), 32'(ref_fwd(ex_rs2_id)));
        check("halted",      32'(halted),      32'(m_halted));
        check("stall_count", 32'(stall_count), 32'(m_stall));
        check("flush_count", 32'(flush_count), 32'(m_flush));
    endtask

    // Clock edge: advance the model with the inputs that were applied, return at negedge.
    task automatic tick();
        bit run;
        @(posedge clk);
        run = ref_running();
        if (reset) begin
            m_drain = 0; m_halted = 1'b0; m_stall = 0; m_flush = 0;
        end else if (run) begin
            if (ex_valid && ex_is_halted) m_drain = DRAIN_CYCLES;
            else if (ex_mispredict)       m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
            else if (ref_load_use())      m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
        end else if (m_drain > 0) begin
            m_drain--;
            if (m_drain == 0) m_halted = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic idle();
        id_valid = 0; id_rs1_id = 0; id_rs2_id = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_valid = 0; ex_wb_enable = 0; ex_mem_enable = 0; ex_mem_write = 0;
        ex_is_halted = 0; ex_rd_id = 0; ex_rs1_id = 0; ex_rs2_id = 0; ex_mispredict = 0;
        mem_valid = 0; mem_wb_enable = 0; mem_ex_forwardable = 0; mem_rd_id = 0;
        wb_valid = 0; wb_wb_enable = 0; wb_rd_id = 0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ex_valid = 1; ex_mem_enable = 1; ex_mem_write = 0; ex_wb_enable = 1; ex_rd_id = rd;
        id_valid = 1; id_uses_rs1 = 1; id_rs1_id = rd;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic randomize_inputs();
        id_valid = 1'($urandom); id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
        id_rs1_id = 5'($urandom_range(3, 0)); id_rs2_id = 5'($urandom_range(3, 0));
        ex_valid = 1'($urandom); ex_wb_enable = 1'($urandom);
        ex_mem_enable = 1'($urandom); ex_mem_write = 1'($urandom);
        ex_is_halted = ($urandom_range(39, 0) == 0);
        ex_rd_id = 5'($urandom_range(3, 0));
        ex_rs1_id = 5'($urandom_range(3, 0)); ex_rs2_id = 5'($urandom_range(3, 0));
        ex_mispredict = ($urandom_range(5, 0) == 0);
        mem_valid = 1'($urandom); mem_wb_enable = 1'($urandom);
        mem_ex_forwardable = 1'($urandom); mem_rd_id = 5'($urandom_range(3, 0));
        wb_valid = 1'($urandom); wb_wb_enable = 1'($urandom);
        wb_rd_id = 5'($urandom_range(3, 0));
        reset = ($urandom_range(29, 0) == 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1;
        idle();
        @(negedge clk);
        tick();
        reset = 0;

        // Reset state.
        settle();
        check("rst_pc_write", 32'(pc_write), 32'd1);
        tick();

        // Load-use on rs1 = x5: one bubble, then the bubble is in EX and ID proceeds.
        set_load_use(5'd5);
        settle();
        check("lu_pc_write", 32'(pc_write), 32'd0);
        check("lu_bubble", 32'(idex_bubble), 32'd1);
        tick();
        ex_valid = 0;
        settle();
        check("lu_release", 32'(pc_write), 32'd1);
        check("lu_count", 32'(stall_count), 32'd1);
        tick();
        idle();
        set_load_use(5'd0);
        settle();
        check("lu_x0_no_stall", 32'(idex_bubble), 32'd0);
        tick();

        // Forwarding priority.
        idle();
        ex_rs1_id = 7; ex_rs2_id = 7;
        mem_valid = 1; mem_wb_enable = 1; mem_ex_forwardable = 1; mem_rd_id = 7;
        wb_valid = 1; wb_wb_enable = 1; wb_rd_id = 7;
        settle();
        check("fwd_mem_wins", 32'(fwd_rs1_sel), 32'd1);
        mem_ex_forwardable = 0;
        settle();
        check("fwd_wb", 32'(fwd_rs1_sel), 32'd2);
        mem_ex_forwardable = 1; mem_rd_id = 0; wb_rd_id = 0;
        settle();
        check("fwd_x0", 32'(fwd_rs1_sel), 32'd0);
        tick();

        // Mispredict with a concurrent load-use.
        idle();
        set_load_use(5'd3);
        ex_mispredict = 1;
        settle();
        check("mp_flush", 32'(ifid_flush), 32'd1);
        check("mp_pc_write", 32'(pc_write), 32'd1);
        tick();
        idle();
        settle();
        check("mp_flush_count", 32'(flush_count), 32'd1);
        check("mp_stall_count", 32'(stall_count), 32'd1);
        tick();

        // Halt with simultaneous mispredict: freeze immediately, halted after the third edge.
        ex_valid = 1; ex_is_halted = 1; ex_mispredict = 1;
        settle();
        check("halt_freeze", 32'(pc_write), 32'd0);
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            settle();
            check("halt_not_yet", 32'(halted), 32'd0);
            tick();
        end
        step();
        settle();
        check("halt_set", 32'(halted), 32'd1);
        check("halt_no_flush", 32'(flush_count), 32'd1);
        tick();
        repeat (4) step();

        // Reset in the second drain cycle.
        do_reset();
        ex_valid = 1; ex_is_halted = 1;
        step();
        idle();
        step();
        reset = 1;
        step();
        reset = 0;
        settle();
        check("rst_drain_pc", 32'(pc_write), 32'd1);
        check("rst_drain_halted", 32'(halted), 32'd0);
        tick();

        // Saturation of the 4-bit stall counter.
        set_load_use(5'd9);
        repeat (20) step();
        settle();
        check("stall_saturate", 32'(stall_count), 32'd15);
        tick();

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
